// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one N-bit word per cycle, LSW first, carry held in a register.
// Latency WORDS+1 cycles from accept to out_valid; result held while out_ready is low.

module n_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[N];
    end
endmodule

module mp_add_seq #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   sum,
    output logic                 co,
    output logic                 ovf
);
    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_r, b_r, sum_r;
    logic          co_r, ovf_r;
    logic [N-1:0]  add_a, add_b, add_s;
    logic          add_co;
    logic          last;

    assign add_a = a_r[idx*N +: N];
    assign add_b = b_r[idx*N +: N];
    assign last  = (idx == IW'(WORDS - 1));

    n_adder #(.N(N)) u_add (
        .a  (add_a),
        .b  (add_b),
        .ci (carry),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // b_r holds the effective operand (already inverted for subtract), so ovf uses its MSB directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum_r <= '0;
            co_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= sub ? ~b : b;
                    carry <= sub;
                    idx   <= '0;
                end
                RUN: begin
                    sum_r[idx*N +: N] <= add_s;
                    carry             <= add_co;
                    idx               <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        co_r  <= add_co;
                        ovf_r <= (a_r[W-1] == b_r[W-1]) && (add_s[N-1] != a_r[W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_r;
    assign co        = co_r;
    assign ovf       = ovf_r;
endmodule
